// File: rtl/dcache_responder_if.sv
// Core dcache port plus backing-memory request/response channel.
// The responder uses the slave modport; the core and memory side use master.
interface dcache_responder_if;
  logic [31:0] cpu_addr;
  logic        cpu_re;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rw;
  logic [29:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  modport slave (
    input  cpu_addr, cpu_re, cpu_we, cpu_din,
    output cpu_dout, stall,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport master (
    output cpu_addr, cpu_re, cpu_we, cpu_din,
    input  cpu_dout, stall,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache with 1-word lines.
// Misses and every store go to backing memory; the core is stalled meanwhile.
module dcache_responder #(
  parameter int LINES = 64
) (
  input logic             clk,
  input logic             reset,
  dcache_responder_if.slave bus
);
  localparam int IDX = $clog2(LINES);
  localparam int TAG = 30 - IDX;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;

  state_t state_reg, state_next;

  logic [31:0]    data_mem [LINES];
  logic [TAG-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid_reg;
  logic [31:0]    dout_reg;

  logic [IDX-1:0] index;
  logic [TAG-1:0] tag;
  logic [31:0]    line_data;
  logic [31:0]    merged;
  logic           line_hit;
  logic           rd_hit;
  logic           wr_hit;
  logic           fill;
  logic           unused_addr_bits;

  assign index            = bus.cpu_addr[IDX-1:0];
  assign tag              = bus.cpu_addr[29:IDX];
  assign line_data        = data_mem[index];
  assign line_hit         = valid_reg[index] && (tag_mem[index] == tag);
  assign unused_addr_bits = ^bus.cpu_addr[31:30];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign merged[gi*8 +: 8] = bus.cpu_we[gi] ? bus.cpu_din[gi*8 +: 8] : line_data[gi*8 +: 8];
    end
  endgenerate

  // DONE accepts the next request exactly like IDLE, so back-to-back accesses lose no cycle.
  always_comb begin
    state_next = state_reg;
    rd_hit     = 1'b0;
    wr_hit     = 1'b0;
    fill       = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (|bus.cpu_we) begin
          wr_hit     = line_hit;
          state_next = WR_REQ;
        end else if (bus.cpu_re) begin
          if (line_hit) rd_hit = 1'b1;
          else          state_next = RD_REQ;
        end
      end
      RD_REQ:  if (bus.mem_req_ready) state_next = RD_WAIT;
      RD_WAIT: begin
        if (bus.mem_resp_valid) begin
          fill       = 1'b1;
          state_next = DONE;
        end
      end
      WR_REQ:  if (bus.mem_req_ready) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      valid_reg <= '0;
      dout_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (fill) valid_reg[index] <= 1'b1;
      if (rd_hit)    dout_reg <= line_data;
      else if (fill) dout_reg <= bus.mem_resp_data;
    end
  end

  // Line storage carries no reset; the valid bits alone decide whether it is meaningful.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_mem[index] <= bus.mem_resp_data;
      tag_mem[index]  <= tag;
    end else if (wr_hit) begin
      data_mem[index] <= merged;
    end
  end

  assign bus.stall         = (state_reg == RD_REQ) || (state_reg == RD_WAIT) || (state_reg == WR_REQ);
  assign bus.mem_req_valid = (state_reg == RD_REQ) || (state_reg == WR_REQ);
  assign bus.mem_req_rw    = (state_reg == WR_REQ);
  assign bus.mem_req_addr  = bus.cpu_addr[29:0];
  assign bus.mem_req_data  = bus.cpu_din;
  assign bus.mem_req_mask  = (state_reg == WR_REQ) ? bus.cpu_we : 4'b0000;
  assign bus.cpu_dout      = dout_reg;
endmodule
